mac_dot_seq: RTL

Sequencer that computes a dot product of two signed vectors on the shared mac_top unit without CPU involvement.
- Accepts a command (length and two base addresses) over a valid/ready handshake.
- Reads operand pairs from an external dual-read operand memory.
- Clears the MAC accumulator, issues one start pulse per element and waits on the MAC ready.
- Returns the final accumulator value over a valid/ready result handshake.

---
 rtl/mac_dot_seq.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/mac_dot_seq.sv
// Dot-product sequencer: streams operand pairs from a dual-read memory
// through mac_top and returns the final accumulator value.
module mac_dot_seq #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 40,
    parameter int ADDR_WIDTH = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH:0]   cmd_len,
    input  logic [ADDR_WIDTH-1:0] cmd_base_a,
    input  logic [ADDR_WIDTH-1:0] cmd_base_b,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr_a,
    output logic [ADDR_WIDTH-1:0] mem_addr_b,
    input  logic [DATA_WIDTH-1:0] mem_rdata_a,
    input  logic [DATA_WIDTH-1:0] mem_rdata_b,
    output logic                  mac_start,
    output logic                  mac_clr_acc,
    output logic [DATA_WIDTH-1:0] mac_a,
    output logic [DATA_WIDTH-1:0] mac_b,
    input  logic [ACC_WIDTH-1:0]  mac_acc,
    input  logic                  mac_ready,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [ACC_WIDTH-1:0]  res_data,
    output logic                  res_err,
    output logic                  busy
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] ONE     = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [TW-1:0]       T_LAST  = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0]       T_ONE   = TW'(1);

    typedef enum logic [2:0] {
        IDLE, CLEAR, FETCH, LOAD, START, WAIT, SETTLE, DONE
    } state_t;

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH:0]     len_q;
    logic [ADDR_WIDTH-1:0]   base_a_q, base_b_q, idx;
    logic [TW-1:0]           tcnt;
    logic                    last_elem, len_zero, timed_out;

    assign last_elem = ({1'b0, idx} == (len_q - ONE));
    assign len_zero  = (len_q == '0);
    assign timed_out = (tcnt == T_LAST);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:   if (cmd_valid) state_nxt = CLEAR;
            CLEAR:  state_nxt = len_zero ? DONE : FETCH;
            FETCH:  state_nxt = LOAD;
            LOAD:   state_nxt = START;
            START:  state_nxt = WAIT;
            WAIT: begin
                if (mac_ready)      state_nxt = SETTLE;
                else if (timed_out) state_nxt = DONE;
            end
            SETTLE: state_nxt = last_elem ? DONE : FETCH;
            DONE:   if (res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready   = 1'b0;
        mem_rd_en   = 1'b0;
        mem_addr_a  = '0;
        mem_addr_b  = '0;
        mac_start   = 1'b0;
        mac_clr_acc = 1'b0;
        res_valid   = 1'b0;
        busy        = (state != IDLE);
        unique case (state)
            IDLE:  cmd_ready = 1'b1;
            CLEAR: mac_clr_acc = 1'b1;
            FETCH: begin
                mem_rd_en  = 1'b1;
                mem_addr_a = base_a_q + idx;
                mem_addr_b = base_b_q + idx;
            end
            START: mac_start = 1'b1;
            DONE:  res_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath; the result registers only change on the way into DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_q    <= '0;
            base_a_q <= '0;
            base_b_q <= '0;
            idx      <= '0;
            tcnt     <= '0;
            mac_a    <= '0;
            mac_b    <= '0;
            res_data <= '0;
            res_err  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (cmd_valid) begin
                    len_q    <= (cmd_len > MAX_LEN) ? MAX_LEN : cmd_len;
                    base_a_q <= cmd_base_a;
                    base_b_q <= cmd_base_b;
                end
                CLEAR: begin
                    idx <= '0;
                    if (len_zero) begin
                        res_data <= '0;
                        res_err  <= 1'b0;
                    end
                end
                LOAD: begin
                    mac_a <= mem_rdata_a;
                    mac_b <= mem_rdata_b;
                end
                START: tcnt <= '0;
                WAIT: begin
                    tcnt <= tcnt + T_ONE;
                    if (!mac_ready && timed_out) begin
                        res_data <= '0;
                        res_err  <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (last_elem) begin
                        res_data <= mac_acc;
                        res_err  <= 1'b0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
